// File: rtl/brightness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : brightness_ctrl
//  Purpose  : Frame-synchronous BPM/enable controller for the brightness
//             filter, with per-frame ramp limiting and fade-in/fade-out.
//             Optional active-frame counter: BRIGHTNESS_CTRL_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module brightness_ctrl #(
    parameter int MAX_BPM   = 200,
    parameter int RAMP_STEP = 4,
    localparam int BW       = $clog2(MAX_BPM + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] bpm_in,
    input  logic          bpm_valid,
    output logic          bpm_ready,
    input  logic          enable_req,
    input  logic          sof,
    output logic          filter_enable,
    output logic [BW-1:0] bpm_applied,
    output logic [1:0]    ctrl_state,
    output logic [15:0]   frame_count
);

    localparam logic [BW-1:0] c_max  = BW'(MAX_BPM);
    localparam logic [BW:0]   c_step = (BW+1)'((RAMP_STEP > MAX_BPM) ? MAX_BPM : RAMP_STEP);

    typedef enum logic [1:0] {
        c_idle      = 2'd0,
        c_ramp_up   = 2'd1,
        c_track     = 2'd2,
        c_ramp_down = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_filter_enable;
    logic [BW-1:0] r_applied;
    logic [BW-1:0] r_target;
    logic [BW-1:0] r_pending;
    logic          r_pending_full;

    logic          w_xfer;
    logic [BW-1:0] w_clamped;
    logic [BW-1:0] w_target_nxt;
    logic [BW-1:0] w_step_tgt;
    logic [BW-1:0] w_step_zero;

    // One-unit move of at most c_step toward goal; extra bit keeps differences exact.
    function automatic logic [BW-1:0] step_toward(input logic [BW-1:0] cur,
                                                  input logic [BW-1:0] goal);
        logic [BW:0] c;
        logic [BW:0] g;
        logic [BW:0] d;
        c = {1'b0, cur};
        g = {1'b0, goal};
        if (c < g) begin
            d = g - c;
            if (d > c_step) d = c_step;
            step_toward = BW'(c + d);
        end else if (c > g) begin
            d = c - g;
            if (d > c_step) d = c_step;
            step_toward = BW'(c - d);
        end else begin
            step_toward = cur;
        end
    endfunction

    assign bpm_ready = !r_pending_full;
    assign w_xfer    = bpm_valid && bpm_ready;
    assign w_clamped = (bpm_in > c_max) ? c_max : bpm_in;

    always_comb begin
        w_target_nxt = r_target;
        if (sof) begin
            if (w_xfer)              w_target_nxt = w_clamped;
            else if (r_pending_full) w_target_nxt = r_pending;
        end
    end

    assign w_step_tgt  = step_toward(r_applied, w_target_nxt);
    assign w_step_zero = step_toward(r_applied, '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= c_idle;
            r_filter_enable <= 1'b0;
            r_applied       <= '0;
            r_target        <= '0;
            r_pending       <= '0;
            r_pending_full  <= 1'b0;
        end else if (sof) begin
            // A same-cycle transfer bypasses the pending slot, so it always ends empty.
            r_target       <= w_target_nxt;
            r_pending_full <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (enable_req) begin
                        r_state         <= c_ramp_up;
                        r_filter_enable <= 1'b1;
                        r_applied       <= w_step_tgt;
                    end
                end
                c_ramp_up: begin
                    if (!enable_req) begin
                        r_state   <= c_ramp_down;
                        r_applied <= w_step_zero;
                    end else begin
                        r_applied <= w_step_tgt;
                        if (w_step_tgt == w_target_nxt) r_state <= c_track;
                    end
                end
                c_track: begin
                    if (!enable_req) begin
                        r_state   <= c_ramp_down;
                        r_applied <= w_step_zero;
                    end else begin
                        r_applied <= w_step_tgt;
                    end
                end
                c_ramp_down: begin
                    if (enable_req) begin
                        r_state   <= c_ramp_up;
                        r_applied <= w_step_tgt;
                    end else begin
                        r_applied <= w_step_zero;
                        if (w_step_zero == '0) begin
                            r_state         <= c_idle;
                            r_filter_enable <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end else if (w_xfer) begin
            r_pending      <= w_clamped;
            r_pending_full <= 1'b1;
        end
    end

    assign filter_enable = r_filter_enable;
    assign bpm_applied   = r_applied;
    assign ctrl_state    = r_state;

`ifdef BRIGHTNESS_CTRL_STATS_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_count <= 16'h0000;
        end else if (sof && r_filter_enable && (r_frame_count != 16'hFFFF)) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_brightness_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_brightness_ctrl
//  Purpose  : Self-checking bench for brightness_ctrl against a frame-level
//             reference model. Honours BRIGHTNESS_CTRL_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_brightness_ctrl;

    localparam int MAX_BPM   = 200;
    localparam int RAMP_STEP = 4;
    localparam int BW        = 8;
`ifdef BRIGHTNESS_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int S_IDLE = 0, S_UP = 1, S_TRACK = 2, S_DOWN = 3;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [BW-1:0] bpm_in     = '0;
    logic          bpm_valid  = 1'b0;
    logic          enable_req = 1'b0;
    logic          sof        = 1'b0;
    logic          bpm_ready;
    logic          filter_enable;
    logic [BW-1:0] bpm_applied;
    logic [1:0]    ctrl_state;
    logic [15:0]   frame_count;

    brightness_ctrl #(.MAX_BPM(MAX_BPM), .RAMP_STEP(RAMP_STEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .bpm_in       (bpm_in),
        .bpm_valid    (bpm_valid),
        .bpm_ready    (bpm_ready),
        .enable_req   (enable_req),
        .sof          (sof),
        .filter_enable(filter_enable),
        .bpm_applied  (bpm_applied),
        .ctrl_state   (ctrl_state),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level reference model
    int m_pend[$];
    int m_target, m_applied, m_state, m_fe, m_fc;

    function automatic int toward(input int a, input int g);
        if (a < g) return (g - a > RAMP_STEP) ? a + RAMP_STEP : g;
        if (a > g) return (a - g > RAMP_STEP) ? a - RAMP_STEP : g;
        return a;
    endfunction

    function automatic void model_reset();
        m_pend.delete();
        m_target = 0; m_applied = 0; m_state = S_IDLE; m_fe = 0; m_fc = 0;
    endfunction

    function automatic void model_edge();
        bit xfer;
        int cl;
        xfer = bpm_valid && (m_pend.size() == 0);
        cl   = (int'(bpm_in) > MAX_BPM) ? MAX_BPM : int'(bpm_in);
        if (!sof) begin
            if (xfer) m_pend.push_back(cl);
            return;
        end
        if (STATS && m_fe == 1 && m_fc < 65535) m_fc++;
        if (xfer) m_target = cl;
        else if (m_pend.size() != 0) m_target = m_pend.pop_front();
        case (m_state)
            S_IDLE: if (enable_req) begin
                m_state = S_UP; m_fe = 1; m_applied = toward(m_applied, m_target);
            end
            S_UP: if (!enable_req) begin
                m_state = S_DOWN; m_applied = toward(m_applied, 0);
            end else begin
                m_applied = toward(m_applied, m_target);
                if (m_applied == m_target) m_state = S_TRACK;
            end
            S_TRACK: if (!enable_req) begin
                m_state = S_DOWN; m_applied = toward(m_applied, 0);
            end else begin
                m_applied = toward(m_applied, m_target);
            end
            default: if (enable_req) begin
                m_state = S_UP; m_applied = toward(m_applied, m_target);
            end else begin
                m_applied = toward(m_applied, 0);
                if (m_applied == 0) begin m_state = S_IDLE; m_fe = 0; end
            end
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit en);
        enable_req = en;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
    endtask

    task automatic accept(input int v);
        bpm_in = BW'(v);
        bpm_valid = 1'b1;
        tick();
        bpm_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (5) begin
            bpm_in = BW'($urandom); bpm_valid = 1'($urandom);
            enable_req = 1'($urandom); sof = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if ({filter_enable, bpm_applied, ctrl_state, frame_count} !== 27'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got fe=%0b applied=%0d state=%0d fc=%0d, want all 0",
                         filter_enable, bpm_applied, ctrl_state, frame_count);
            end
        end
        bpm_valid = 1'b0; sof = 1'b0; enable_req = 1'b0;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bpm_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %0b want 1", bpm_ready);
        end
    endtask

    task automatic test_fade_in();
        accept(20);
        n_cmp++;
        if (bpm_ready !== 1'b0) begin
            n_err++; $display("FAIL fadein_pending_ready: got %0b want 0", bpm_ready);
        end
        for (int i = 1; i <= 5; i++) begin
            frame(1'b1);
            n_cmp++;
            if (bpm_applied !== BW'(4 * i) || filter_enable !== 1'b1 ||
                ctrl_state !== ((i == 5) ? 2'd2 : 2'd1)) begin
                n_err++;
                $display("FAIL fadein_sof%0d: got applied=%0d fe=%0b state=%0d want %0d 1 %0d",
                         i, bpm_applied, filter_enable, ctrl_state, 4 * i, (i == 5) ? 2 : 1);
            end
        end
    endtask

    task automatic test_clamp();
        accept(200);
        for (int k = 0; k < 60 && m_applied < 200; k++) frame(1'b1);
        n_cmp++;
        if (bpm_applied !== 8'd200 || ctrl_state !== 2'd2) begin
            n_err++;
            $display("FAIL clamp_reach200: got applied=%0d state=%0d want 200 2", bpm_applied, ctrl_state);
        end
        accept(250);
        for (int k = 0; k < 2; k++) begin
            frame(1'b1);
            n_cmp++;
            if (bpm_applied !== 8'd200 || bpm_ready !== 1'b1) begin
                n_err++;
                $display("FAIL clamp_hold%0d: got applied=%0d ready=%0b want 200 1", k, bpm_applied, bpm_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        accept(30);
        bpm_in = 8'd40;
        bpm_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (bpm_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_ready_low%0d: got %0b want 0", k, bpm_ready);
            end
            tick();
        end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        n_cmp++;
        if (bpm_ready !== 1'b1 || bpm_applied !== 8'd196) begin
            n_err++;
            $display("FAIL bp_after_sof: got ready=%0b applied=%0d want 1 196", bpm_ready, bpm_applied);
        end
        tick();
        bpm_valid = 1'b0;
        n_cmp++;
        if (bpm_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_second_accept: got ready=%0b want 0", bpm_ready);
        end
    endtask

    task automatic test_fade_out();
        int fc0;
        frame(1'b1);
        accept(10);
        for (int k = 0; k < 80 && !(m_applied == 10 && m_state == S_TRACK); k++) frame(1'b1);
        n_cmp++;
        if (bpm_applied !== 8'd10 || ctrl_state !== 2'd2) begin
            n_err++;
            $display("FAIL fadeout_track10: got applied=%0d state=%0d want 10 2", bpm_applied, ctrl_state);
        end
        fc0 = m_fc;
        for (int i = 0; i < 3; i++) begin
            frame(1'b0);
            n_cmp++;
            if (bpm_applied !== BW'(6 - 4 * i > 0 ? 6 - 4 * i : 0) ||
                filter_enable !== ((i == 2) ? 1'b0 : 1'b1) ||
                ctrl_state !== ((i == 2) ? 2'd0 : 2'd3)) begin
                n_err++;
                $display("FAIL fadeout_sof%0d: got applied=%0d fe=%0b state=%0d", i + 1,
                         bpm_applied, filter_enable, ctrl_state);
            end
        end
        frame(1'b0);
        n_cmp++;
        if (frame_count !== (STATS ? 16'(fc0 + 3) : 16'd0)) begin
            n_err++;
            $display("FAIL fadeout_frame_count: got %0d want %0d", frame_count, STATS ? fc0 + 3 : 0);
        end
    endtask

    task automatic test_async_reset();
        accept(20);
        frame(1'b1);
        frame(1'b1);
        n_cmp++;
        if (bpm_applied !== 8'd8 || ctrl_state !== 2'd1) begin
            n_err++;
            $display("FAIL areset_pre: got applied=%0d state=%0d want 8 1", bpm_applied, ctrl_state);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({filter_enable, bpm_applied, ctrl_state, frame_count} !== 27'd0) begin
            n_err++;
            $display("FAIL areset_immediate: got fe=%0b applied=%0d state=%0d fc=%0d want all 0",
                     filter_enable, bpm_applied, ctrl_state, frame_count);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bpm_in = 8'd20; bpm_valid = 1'b1; enable_req = 1'b1; sof = 1'b1;
        tick();
        bpm_valid = 1'b0; sof = 1'b0;
        n_cmp++;
        if (bpm_applied !== 8'd4 || ctrl_state !== 2'd1 || filter_enable !== 1'b1) begin
            n_err++;
            $display("FAIL areset_restart: got applied=%0d state=%0d fe=%0b want 4 1 1",
                     bpm_applied, ctrl_state, filter_enable);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            if (!(bpm_valid && !bpm_ready)) begin
                bpm_valid = ($urandom_range(0, 2) != 0);
                bpm_in    = BW'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 39) == 0) enable_req = ~enable_req;
            sof = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (bpm_applied !== BW'(m_applied) || filter_enable !== 1'(m_fe) ||
                ctrl_state !== 2'(m_state) || bpm_ready !== (m_pend.size() == 0) ||
                frame_count !== 16'(m_fc)) begin
                n_err++;
                $display("FAIL random_c%0d: got applied=%0d fe=%0b state=%0d ready=%0b fc=%0d want %0d %0d %0d %0b %0d",
                         c, bpm_applied, filter_enable, ctrl_state, bpm_ready, frame_count,
                         m_applied, m_fe, m_state, m_pend.size() == 0, m_fc);
            end
        end
        bpm_valid = 1'b0; sof = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_fade_in();
        test_clamp();
        test_backpressure();
        test_fade_out();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brightness_ctrl.md
Name: brightness_ctrl

Overview:
- Frame-synchronous controller for the pixel-wise brightness filter.
- Accepts BPM estimates over a valid/ready handshake, buffers one pending value, and clamps it to MAX_BPM.
- Produces the filter's filter_enable and BPM_estimate inputs. Both change only on start-of-frame pulses, so a frame is never filtered with mixed settings.
- Ramps the applied BPM by at most RAMP_STEP per frame to avoid visible brightness jumps. Also handles fade-in and fade-out when the filter is switched on or off.

Parameters:
- MAX_BPM, 200, upper clamp for any accepted BPM; sets BW = $clog2(MAX_BPM+1).
- RAMP_STEP, 4, maximum change of bpm_applied per sof pulse; must be >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- bpm_in  in  BW  BPM estimate from the rate detector.
- bpm_valid  in  1  bpm_in is valid.
- bpm_ready  out  1  controller can accept bpm_in.
- enable_req  in  1  user/switch request to enable the filter; level-sensitive.
- sof  in  1  one-cycle start-of-frame pulse from the video stream.
- filter_enable  out  1  drives the filter's filter_enable.
- bpm_applied  out  BW  drives the filter's BPM_estimate.
- ctrl_state  out  2  IDLE=0, RAMP_UP=1, TRACK=2, RAMP_DOWN=3.
- frame_count  out  16  active-frame statistics (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, filter_enable=0, bpm_applied=0, target=0, pending empty, frame_count=0.
  - bpm_ready=1 from the first cycle after release.
- Handshake: a transfer occurs when bpm_valid && bpm_ready on a clk edge.
  - The accepted value is min(bpm_in, MAX_BPM) and is stored in the pending register.
  - bpm_ready = !pending_full; it is combinational from that register.
  - bpm_valid without bpm_ready: the source holds bpm_in; nothing is stored.
- On sof, if pending is full: target <= pending and pending clears, so bpm_ready=1 on the next cycle.
- If sof and a transfer occur in the same cycle: the clamped bpm_in becomes target directly and pending stays empty.
- No output changes except on a sof edge, apart from reset and bpm_ready.
- Step function toward goal G:
  - if applied<G: applied + min(RAMP_STEP, G-applied);
  - if applied>G: applied - min(RAMP_STEP, applied-G);
  - otherwise unchanged.
  - Arithmetic uses BW+1 bits; no wrap or underflow.
- FSM transitions, evaluated only when sof=1, using the target value after the sof update above:
  - IDLE: if enable_req, go to RAMP_UP, filter_enable<=1, applied<=step(target). Otherwise stay; applied stays 0.
  - RAMP_UP: if !enable_req, go to RAMP_DOWN and applied<=step(0). Otherwise applied<=step(target); if the new applied==target, go to TRACK.
  - TRACK: if !enable_req, go to RAMP_DOWN and applied<=step(0). Otherwise applied<=step(target) and stay in TRACK, so target changes are still rate-limited.
  - RAMP_DOWN: if enable_req, go to RAMP_UP and applied<=step(target). Otherwise applied<=step(0); if the new applied==0, go to IDLE and filter_enable<=0 on the same edge.
  - target==0 while enabling: RAMP_UP goes to TRACK on its first sof, with applied=0 and filter_enable=1.
- Mid-frame enable_req toggles are ignored until the next sof.
- Reset asserted mid-ramp returns everything to reset values immediately; no fade-out.

Optional Feature:
- Macro BRIGHTNESS_CTRL_STATS_EN.
- Defined: frame_count increments on every sof edge where filter_enable=1 before the edge. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the counter is not built and frame_count is tied to 0. The port list is unchanged.

Test Plan:
- Reset: hold reset=0 with random inputs -> filter_enable=0, bpm_applied=0, ctrl_state=0, frame_count=0; bpm_ready=1 after release.
- Fade-in: accept bpm 20, enable_req=1, five sof pulses -> bpm_applied 4,8,12,16,20; ctrl_state reaches TRACK on the 5th sof; filter_enable=1 from the 1st.
- Clamp: accept bpm_in=250 in TRACK at applied 200 -> target 200, bpm_applied stays 200.
- Backpressure: accept 30, then present 40 -> bpm_ready=0, 40 held. At sof the target becomes 30; bpm_ready=1 next cycle and 40 is accepted.
- Fade-out: TRACK at 10, drop enable_req, sof pulses -> bpm_applied 6,2,0; filter_enable=0 and IDLE on the 3rd sof. With STATS_EN, frame_count has counted exactly the enabled frames.
- Async reset mid RAMP_UP at applied 8 -> outputs 0 without a clk edge; the next sof with enable_req restarts at 4.
